// File: rtl/fifo_ptr_ctrl_pkg.sv
// fifo_pkg: shared defaults, level type and wrap-around pointer helper for the
// sample FIFO pointer controller.
package fifo_pkg;

  localparam int FIFO_DEPTH_DFLT = 64;
  localparam int FIFO_AW_DFLT    = 8;
  localparam int FIFO_CALC_W     = 16;

  typedef logic [FIFO_AW_DFLT-1:0] fifo_lvl_t;
  typedef logic [FIFO_CALC_W-1:0]  fifo_calc_t;

  // Wrap by explicit compare so that non-power-of-two depths work.
  function automatic fifo_calc_t ptr_inc(input fifo_calc_t ptr, input fifo_calc_t depth);
    return (ptr == depth - fifo_calc_t'(1)) ? '0 : ptr + fifo_calc_t'(1);
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/strobe/address bundle between the sample path and the FIFO pointer
// controller; the controller takes the slave side.
interface fifo_ptr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW_DFLT
) ();

  logic          wr_req;
  logic          rd_req;
  logic          wr_en;
  logic          rd_en;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  modport master (
    output wr_req, rd_req,
    input  wr_en, wr_addr, rd_en, rd_addr
  );

  modport slave (
    input  wr_req, rd_req,
    output wr_en, wr_addr, rd_en, rd_addr
  );

endinterface

// File: rtl/fifo_ptr_ctrl_wl_det.sv
// fifo_wl_det: registered waterline flag computed from the next-state level.
// Hysteresis on the falling side is enabled by defining FIFO_WL_HYST_EN.
module fifo_wl_det
  import fifo_pkg::*;
#(
  parameter int AW = FIFO_AW_DFLT
) (
  input  logic          clk_32k,
  input  logic          rst,
  input  logic [AW-1:0] lvl_nxt,
  input  logic [AW-1:0] rg_waterline,
  input  logic [3:0]    rg_wl_hyst,
  input  logic          flush,
  output logic          wl_flag
);

  logic wl_q;
  logic wl_d;
  logic wl_enabled;
  logic wl_above;

  assign wl_enabled = (rg_waterline != '0);
  assign wl_above   = (lvl_nxt >= rg_waterline);

`ifdef FIFO_WL_HYST_EN
  fifo_calc_t low_mark;

  // Release threshold saturates at zero; a zero mark means only flush clears the flag.
  assign low_mark = (FIFO_CALC_W'(rg_waterline) > FIFO_CALC_W'(rg_wl_hyst)) ?
                    (FIFO_CALC_W'(rg_waterline) - FIFO_CALC_W'(rg_wl_hyst)) : '0;

  always_comb begin
    wl_d = wl_q;
    if (!wl_enabled) begin
      wl_d = 1'b0;
    end else if (!wl_q) begin
      wl_d = wl_above;
    end else if (FIFO_CALC_W'(lvl_nxt) < low_mark) begin
      wl_d = 1'b0;
    end
  end
`else
  logic unused_hyst;
  assign unused_hyst = ^rg_wl_hyst;

  always_comb begin
    wl_d = wl_enabled & wl_above;
  end
`endif

  always_ff @(posedge clk_32k) begin
    if (rst || flush) begin
      wl_q <= 1'b0;
    end else begin
      wl_q <= wl_d;
    end
  end

  assign wl_flag = wl_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: pointer, level, overflow/underflow and waterline flag control
// for the 32 kHz sample FIFO (waterline hysteresis via FIFO_WL_HYST_EN).
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DFLT,
  parameter int AW    = FIFO_AW_DFLT
) (
  input  logic           clk_32k,
  input  logic           rst,
  fifo_ptr_ctrl_if.slave bus,
  input  logic           rg_fifo_flush,
  input  logic [AW-1:0]  rg_waterline,
  input  logic [3:0]     rg_wl_hyst,
  output logic [AW-1:0]  fifo_level,
  output logic           fifo_full,
  output logic           fifo_empty,
  output logic           fifo_upov_flag,
  output logic           fifo_downov_flag,
  output logic           fifo_waterline_flag,
  output logic [7:0]     ov_cnt
);

  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW-1:0] level_q;
  logic [AW-1:0] lvl_nxt;
  logic [AW-1:0] wr_ptr_nxt;
  logic [AW-1:0] rd_ptr_nxt;
  logic          upov_q;
  logic          downov_q;
  logic [7:0]    ov_cnt_q;
  logic          wr_ok;
  logic          rd_ok;
  logic          wr_rej;
  logic          rd_rej;

  assign fifo_full  = (level_q == AW'(DEPTH));
  assign fifo_empty = (level_q == '0);

  // A flush cycle swallows both requests without accepting or flagging them.
  always_comb begin
    wr_ok  = 1'b0;
    rd_ok  = 1'b0;
    wr_rej = 1'b0;
    rd_rej = 1'b0;
    if (!rg_fifo_flush) begin
      wr_ok  = bus.wr_req & (~fifo_full | bus.rd_req);
      rd_ok  = bus.rd_req & ~fifo_empty;
      wr_rej = bus.wr_req & ~wr_ok;
      rd_rej = bus.rd_req & ~rd_ok;
    end
  end

  always_comb begin
    lvl_nxt = level_q;
    if (rg_fifo_flush) begin
      lvl_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      lvl_nxt = level_q + AW'(1);
    end else if (rd_ok && !wr_ok) begin
      lvl_nxt = level_q - AW'(1);
    end
  end

  assign wr_ptr_nxt = AW'(ptr_inc(FIFO_CALC_W'(wr_ptr_q), FIFO_CALC_W'(DEPTH)));
  assign rd_ptr_nxt = AW'(ptr_inc(FIFO_CALC_W'(rd_ptr_q), FIFO_CALC_W'(DEPTH)));

  // Overflow flags set on a rejected request win over a same-cycle clear.
  always_ff @(posedge clk_32k) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      upov_q   <= 1'b0;
      downov_q <= 1'b0;
      ov_cnt_q <= '0;
    end else if (rg_fifo_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      upov_q   <= 1'b0;
      downov_q <= 1'b0;
    end else begin
      level_q <= lvl_nxt;
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_nxt;
      end
      if (rd_ok) begin
        rd_ptr_q <= rd_ptr_nxt;
      end
      if (wr_rej) begin
        upov_q <= 1'b1;
      end else if (rd_ok) begin
        upov_q <= 1'b0;
      end
      if (rd_rej) begin
        downov_q <= 1'b1;
      end else if (wr_ok) begin
        downov_q <= 1'b0;
      end
      if (wr_rej && (ov_cnt_q != 8'hFF)) begin
        ov_cnt_q <= ov_cnt_q + 8'd1;
      end
    end
  end

  fifo_wl_det #(
    .AW (AW)
  ) u_wl_det (
    .clk_32k      (clk_32k),
    .rst          (rst),
    .lvl_nxt      (lvl_nxt),
    .rg_waterline (rg_waterline),
    .rg_wl_hyst   (rg_wl_hyst),
    .flush        (rg_fifo_flush),
    .wl_flag      (fifo_waterline_flag)
  );

  assign bus.wr_en        = wr_ok;
  assign bus.rd_en        = rd_ok;
  assign bus.wr_addr      = wr_ptr_q;
  assign bus.rd_addr      = rd_ptr_q;
  assign fifo_level       = level_q;
  assign fifo_upov_flag   = upov_q;
  assign fifo_downov_flag = downov_q;
  assign ov_cnt           = ov_cnt_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// tb_fifo_ptr_ctrl: vector table, directed corner sequences (incl. a DEPTH=48
// instance) and randomized traffic against a count-based reference model.
module tb_fifo_ptr_ctrl;
  import fifo_pkg::*;

  localparam int DEPTH   = 64;
  localparam int DEPTH48 = 48;
  localparam int AW      = 8;
`ifdef FIFO_WL_HYST_EN
  localparam int HYST_BUILD = 1;
`else
  localparam int HYST_BUILD = 0;
`endif

  logic          clk_32k;
  logic          rst;
  logic          flush;
  logic [AW-1:0] rg_waterline;
  logic [3:0]    rg_wl_hyst;
  logic [AW-1:0] fifo_level, level48;
  logic          fifo_full, fifo_empty, upov, downov, wl_flag;
  logic          full48, empty48, upov48, downov48, wl48;
  logic [7:0]    ov_cnt, ov48;
  logic          got_wr_en, got_rd_en;

  int checks   = 0;
  int failures = 0;

  fifo_ptr_ctrl_if #(.AW(AW)) bus_a ();
  fifo_ptr_ctrl_if #(.AW(AW)) bus48 ();

  fifo_ptr_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_32k (clk_32k), .rst (rst), .bus (bus_a), .rg_fifo_flush (flush),
    .rg_waterline (rg_waterline), .rg_wl_hyst (rg_wl_hyst),
    .fifo_level (fifo_level), .fifo_full (fifo_full), .fifo_empty (fifo_empty),
    .fifo_upov_flag (upov), .fifo_downov_flag (downov),
    .fifo_waterline_flag (wl_flag), .ov_cnt (ov_cnt)
  );

  fifo_ptr_ctrl #(.DEPTH(DEPTH48), .AW(AW)) dut48 (
    .clk_32k (clk_32k), .rst (rst), .bus (bus48), .rg_fifo_flush (flush),
    .rg_waterline (rg_waterline), .rg_wl_hyst (rg_wl_hyst),
    .fifo_level (level48), .fifo_full (full48), .fifo_empty (empty48),
    .fifo_upov_flag (upov48), .fifo_downov_flag (downov48),
    .fifo_waterline_flag (wl48), .ov_cnt (ov48)
  );

  initial begin
    clk_32k = 1'b0;
    forever #5 clk_32k = ~clk_32k;
  end

  typedef struct {
    bit wr;
    bit rd;
    bit fl;
    int exp_wr_en;
    int exp_rd_en;
    int exp_level;
    int exp_down;
    int exp_wl;
  } vec_t;

  vec_t vecs[8];

  // Reference model: counts of accepted operations since the last flush.
  int m_level, m_wr_cnt, m_rd_cnt, m_up, m_down, m_wl, m_ov;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Called at posedge+1; samples enables mid-cycle and returns at the next posedge+1.
  task automatic applyStimulus(input logic wr, input logic rd, input logic fl);
    bus_a.wr_req = wr;
    bus_a.rd_req = rd;
    flush        = fl;
    @(negedge clk_32k);
    got_wr_en = bus_a.wr_en;
    got_rd_en = bus_a.rd_en;
    @(posedge clk_32k);
    #1;
    bus_a.wr_req = 1'b0;
    bus_a.rd_req = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (3) @(posedge clk_32k);
    #1;
    rst = 1'b0;
    m_level = 0; m_wr_cnt = 0; m_rd_cnt = 0;
    m_up = 0; m_down = 0; m_wl = 0; m_ov = 0;
  endtask

  task automatic modelStep(input logic wr, input logic rd, input logic fl,
                           input int thr, input int hy,
                           output int exp_wr, output int exp_rd);
    int lo;
    exp_wr = 0;
    exp_rd = 0;
    if (fl) begin
      m_level = 0; m_wr_cnt = 0; m_rd_cnt = 0;
      m_up = 0; m_down = 0; m_wl = 0;
    end else begin
      exp_wr = int'(wr && ((m_level != DEPTH) || rd));
      exp_rd = int'(rd && (m_level != 0));
      m_level  = m_level + exp_wr - exp_rd;
      m_wr_cnt = (m_wr_cnt + exp_wr) % DEPTH;
      m_rd_cnt = (m_rd_cnt + exp_rd) % DEPTH;
      if (wr && (exp_wr == 0)) begin
        m_up = 1;
        if (m_ov < 255) m_ov++;
      end else if (exp_rd == 1) begin
        m_up = 0;
      end
      if (rd && (exp_rd == 0)) m_down = 1;
      else if (exp_wr == 1) m_down = 0;
`ifdef FIFO_WL_HYST_EN
      lo = (thr > hy) ? thr - hy : 0;
      if (thr == 0) m_wl = 0;
      else if (m_wl == 0) m_wl = int'(m_level >= thr);
      else if (m_level < lo) m_wl = 0;
`else
      lo = hy;
      m_wl = int'((thr != 0) && (m_level >= thr));
`endif
    end
  endtask

  initial begin
    int seg_wr[5];
    int seg_rd[5];
    int wr_pct, rd_pct, sel, ew, er;
    logic wr, rd, fl;

    rst = 1'b1; flush = 1'b0;
    bus_a.wr_req = 1'b0; bus_a.rd_req = 1'b0;
    bus48.wr_req = 1'b0; bus48.rd_req = 1'b0;
    rg_waterline = 8'd2; rg_wl_hyst = 4'd0;
    got_wr_en = 1'b0; got_rd_en = 1'b0;

    //            wr rd fl  wr_en rd_en level down wl
    vecs[0] = '{1, 0, 0, 1, 0, 1, 0, 0};
    vecs[1] = '{1, 1, 0, 1, 1, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 1, 0, 0, 0};
    vecs[3] = '{0, 1, 0, 0, 0, 0, 1, 0};
    vecs[4] = '{1, 1, 0, 1, 0, 1, 1, 0};
    vecs[5] = '{1, 0, 0, 1, 0, 2, 0, 1};
    vecs[6] = '{1, 0, 1, 0, 0, 0, 0, 0};
    vecs[7] = '{1, 0, 0, 1, 0, 1, 0, 0};

    doReset();
    checkOutput("reset level", int'(fifo_level), 0);
    checkOutput("reset empty", int'(fifo_empty), 1);
    checkOutput("reset full", int'(fifo_full), 0);
    checkOutput("reset upov", int'(upov), 0);
    checkOutput("reset downov", int'(downov), 0);
    checkOutput("reset waterline", int'(wl_flag), 0);
    checkOutput("reset ov_cnt", int'(ov_cnt), 0);
    checkOutput("reset wr_addr", int'(bus_a.wr_addr), 0);
    checkOutput("reset rd_addr", int'(bus_a.rd_addr), 0);

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].rd, vecs[i].fl);
      checkOutput($sformatf("vec%0d wr_en", i), int'(got_wr_en), vecs[i].exp_wr_en);
      checkOutput($sformatf("vec%0d rd_en", i), int'(got_rd_en), vecs[i].exp_rd_en);
      checkOutput($sformatf("vec%0d level", i), int'(fifo_level), vecs[i].exp_level);
      checkOutput($sformatf("vec%0d downov", i), int'(downov), vecs[i].exp_down);
      checkOutput($sformatf("vec%0d waterline", i), int'(wl_flag), vecs[i].exp_wl);
    end

    // Fill to full with waterline at 32.
    doReset();
    rg_waterline = 8'd32;
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("fill wr_en", int'(got_wr_en), 1);
      checkOutput("fill level", int'(fifo_level), k);
      checkOutput("fill wr_addr", int'(bus_a.wr_addr), k % 64);
      checkOutput("fill waterline", int'(wl_flag), int'(k >= 32));
    end
    checkOutput("fill full", int'(fifo_full), 1);

    for (int j = 1; j <= 3; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("ovf wr_en", int'(got_wr_en), 0);
      checkOutput("ovf level", int'(fifo_level), 64);
      checkOutput("ovf upov", int'(upov), 1);
      checkOutput("ovf ov_cnt", int'(ov_cnt), j);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ovf clear rd_en", int'(got_rd_en), 1);
    checkOutput("ovf clear upov", int'(upov), 0);
    checkOutput("ovf clear level", int'(fifo_level), 63);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("refill level", int'(fifo_level), 64);

    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("full rw wr_en", int'(got_wr_en), 1);
      checkOutput("full rw rd_en", int'(got_rd_en), 1);
      checkOutput("full rw level", int'(fifo_level), 64);
      checkOutput("full rw upov", int'(upov), 0);
    end
    checkOutput("full rw wr_addr", int'(bus_a.wr_addr), 11);
    checkOutput("full rw rd_addr", int'(bus_a.rd_addr), 11);

    for (int k = 1; k <= 64; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("drain level", int'(fifo_level), 64 - k);
      checkOutput("drain rd_addr", int'(bus_a.rd_addr), (11 + k) % 64);
      checkOutput("drain waterline", int'(wl_flag), int'((64 - k) >= 32));
    end
    checkOutput("drain empty", int'(fifo_empty), 1);

    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("udf wr_en", int'(got_wr_en), 1);
    checkOutput("udf rd_en", int'(got_rd_en), 0);
    checkOutput("udf level", int'(fifo_level), 1);
    checkOutput("udf downov", int'(downov), 1);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("udf clear downov", int'(downov), 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("udf drained", int'(fifo_level), 0);

    // Waterline 16 with hysteresis 4, then flush at level 20 with a write pending.
    rg_waterline = 8'd16;
    rg_wl_hyst   = 4'd4;
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hyst up waterline", int'(wl_flag), int'(k >= 16));
    end
    for (int k = 19; k >= 11; k--) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("hyst down waterline", int'(wl_flag),
                  int'(k >= ((HYST_BUILD != 0) ? 12 : 16)));
    end
    for (int k = 12; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("hyst reup waterline", int'(wl_flag), int'(k >= 16));
    end
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("flush wr_en", int'(got_wr_en), 0);
    checkOutput("flush level", int'(fifo_level), 0);
    checkOutput("flush waterline", int'(wl_flag), 0);
    checkOutput("flush upov", int'(upov), 0);
    checkOutput("flush downov", int'(downov), 0);
    checkOutput("flush wr_addr", int'(bus_a.wr_addr), 0);
    checkOutput("flush ov_cnt", int'(ov_cnt), 3);

    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midreset level", int'(fifo_level), 0);
    checkOutput("midreset ov_cnt", int'(ov_cnt), 0);
    checkOutput("midreset wr_addr", int'(bus_a.wr_addr), 0);
    checkOutput("midreset empty", int'(fifo_empty), 1);

    // DEPTH=48 instance: address wrap 47->0 and full at 48.
    for (int k = 1; k <= 49; k++) begin
      bus48.wr_req = 1'b1;
      @(negedge clk_32k);
      checkOutput("d48 wr_en", int'(bus48.wr_en), int'(k <= 48));
      @(posedge clk_32k);
      #1;
      checkOutput("d48 wr_addr", int'(bus48.wr_addr), (k <= 48) ? (k % 48) : 0);
      checkOutput("d48 level", int'(level48), (k <= 48) ? k : 48);
    end
    bus48.wr_req = 1'b0;
    checkOutput("d48 full", int'(full48), 1);
    checkOutput("d48 upov", int'(upov48), 1);

    // Randomized traffic against the model.
    seg_wr = '{90, 10, 60, 100, 50};
    seg_rd = '{10, 90, 60, 100, 20};
    wr_pct = 50; rd_pct = 50;
    doReset();
    for (int c = 0; c < 3000; c++) begin
      if ((c % 250) == 0) begin
        sel          = int'($urandom_range(0, 4));
        wr_pct       = seg_wr[sel];
        rd_pct       = seg_rd[sel];
        rg_waterline = 8'($urandom_range(0, 70));
        rg_wl_hyst   = 4'($urandom_range(0, 15));
      end
      wr = ($urandom_range(0, 99) < wr_pct);
      rd = ($urandom_range(0, 99) < rd_pct);
      fl = ($urandom_range(0, 199) == 0);
      bus_a.wr_req = wr;
      bus_a.rd_req = rd;
      flush        = fl;
      @(negedge clk_32k);
      checkOutput("rnd level", int'(fifo_level), m_level);
      checkOutput("rnd wr_addr", int'(bus_a.wr_addr), m_wr_cnt);
      checkOutput("rnd rd_addr", int'(bus_a.rd_addr), m_rd_cnt);
      checkOutput("rnd full", int'(fifo_full), int'(m_level == DEPTH));
      checkOutput("rnd empty", int'(fifo_empty), int'(m_level == 0));
      checkOutput("rnd upov", int'(upov), m_up);
      checkOutput("rnd downov", int'(downov), m_down);
      checkOutput("rnd waterline", int'(wl_flag), m_wl);
      checkOutput("rnd ov_cnt", int'(ov_cnt), m_ov);
      modelStep(wr, rd, fl, int'(rg_waterline), int'(rg_wl_hyst), ew, er);
      checkOutput("rnd wr_en", int'(bus_a.wr_en), ew);
      checkOutput("rnd rd_en", int'(bus_a.rd_en), er);
      @(posedge clk_32k);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
